sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the multi-cycle CPU's instruction-fetch requester and its load/store requester.
- The CPU raises a request, the arbiter grants one requester, captures its command, drives the SRAM, and returns a one-cycle ack with read data.
- It sits between the CPU core and the unified memory, replacing the separate inst/data SRAM ports.

---
 rtl/sram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the fetch and load/store requesters.
// Define ARB_PERF_EN to build the inst_wait_cnt / data_grant_cnt performance counters.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                busy,
  output logic [31:0]         inst_wait_cnt,
  output logic [31:0]         data_grant_cnt
);

  localparam int unsigned        STARV_W   = 4;
  localparam logic [STARV_W-1:0] STARV_MAX = STARV_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [STARV_W-1:0] starv_cnt;
  logic [STARV_W-1:0] starv_cnt_nxt;
  logic               grant_data;
  logic               grant_inst;
  logic               cmd_data;
  logic               cmd_wr;
  logic [DATA_W-1:0]  inst_rdata_q;
  logic [DATA_W-1:0]  data_rdata_q;

  // State and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      starv_cnt <= '0;
    end else begin
      state     <= next_state;
      starv_cnt <= starv_cnt_nxt;
    end
  end

  // Arbitration and next state
  always_comb begin
    next_state    = state;
    grant_data    = 1'b0;
    grant_inst    = 1'b0;
    starv_cnt_nxt = starv_cnt;
    case (state)
      IDLE: begin
        // data normally wins; a fetch passed over STARVE_LIMIT times goes first
        grant_data = data_req && ((starv_cnt < STARV_MAX) || !inst_req);
        grant_inst = inst_req && !grant_data;
        if (grant_data || grant_inst) next_state = ACCESS;
        // at the limit inst wins, so the increment saturates by construction
        if (grant_inst || !inst_req) starv_cnt_nxt = '0;
        else if (grant_data)         starv_cnt_nxt = starv_cnt + STARV_W'(1);
      end
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command capture, SRAM drive, acks and read-data hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_en      <= 1'b0;
      sram_we      <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      cmd_data     <= 1'b0;
      cmd_wr       <= 1'b0;
      inst_ack     <= 1'b0;
      data_ack     <= 1'b0;
      busy         <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      sram_en  <= 1'b0;
      sram_we  <= '0;
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      busy     <= (next_state != IDLE);
      if (grant_data || grant_inst) begin
        sram_en    <= 1'b1;
        sram_we    <= (grant_data && data_wr) ? data_wstrb : '0;
        sram_addr  <= grant_data ? data_addr : inst_addr;
        sram_wdata <= grant_data ? data_wdata : '0;
        cmd_data   <= grant_data;
        cmd_wr     <= grant_data && data_wr;
      end
      if (state == ACCESS) begin
        inst_ack <= !cmd_data;
        data_ack <= cmd_data;
      end
      if (inst_ack)             inst_rdata_q <= sram_rdata;
      if (data_ack && !cmd_wr)  data_rdata_q <= sram_rdata;
    end
  end

  // SRAM output is already registered; forward it during the ack cycle, hold otherwise
  assign inst_rdata = inst_ack ? sram_rdata : inst_rdata_q;
  assign data_rdata = (data_ack && !cmd_wr) ? sram_rdata : data_rdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] inst_wait_q;
  logic [31:0] data_grant_q;

  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_wait_q  <= '0;
      data_grant_q <= '0;
    end else begin
      if (inst_req && !inst_ack) inst_wait_q  <= inst_wait_q + 32'd1;
      if (grant_data)            data_grant_q <= data_grant_q + 32'd1;
    end
  end

  assign inst_wait_cnt  = inst_wait_q;
  assign data_grant_cnt = data_grant_q;
`else
  assign inst_wait_cnt  = '0;
  assign data_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table, directed corner sequences and randomized traffic checked
// against a transaction-level model of the arbiter, with a behavioural SRAM attached.
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int LIMIT = 4;
`ifdef ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        busy;
  logic [31:0] inst_wait_cnt;
  logic [31:0] data_grant_cnt;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy),
    .inst_wait_cnt(inst_wait_cnt), .data_grant_cnt(data_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Synchronous SRAM: read data appears the cycle after sram_en, garbage otherwise
  always @(posedge clk) begin
    if (sram_en && sram_we == 4'h0) sram_rdata <= mem_read(sram_addr);
    else                            sram_rdata <= $urandom;
    if (sram_en && sram_we != 4'h0) mem[sram_addr] = merge(mem_read(sram_addr), sram_wdata, sram_we);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram_en"},    32'(sram_en), 32'h0);
    check({tag, "_sram_we"},    32'(sram_we), 32'h0);
    check({tag, "_sram_addr"},  sram_addr, 32'h0);
    check({tag, "_sram_wdata"}, sram_wdata, 32'h0);
    check({tag, "_inst_ack"},   32'(inst_ack), 32'h0);
    check({tag, "_data_ack"},   32'(data_ack), 32'h0);
    check({tag, "_inst_rdata"}, inst_rdata, 32'h0);
    check({tag, "_data_rdata"}, data_rdata, 32'h0);
    check({tag, "_busy"},       32'(busy), 32'h0);
    check({tag, "_inst_wait"},  inst_wait_cnt, 32'h0);
    check({tag, "_data_grant"}, data_grant_cnt, 32'h0);
  endtask

  typedef struct {
    logic        inst_req;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        preload;
    logic [31:0] pre_val;
    logic [3:0]  exp_we;
    logic        exp_iack;
    logic        exp_dack;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  vec_t v;

  // random-phase model state
  int          free_at, acc_t, ack_t, starv, r;
  bit          win_data, win_wr, inst_flight, data_flight;
  bit          e_en, e_iack, e_dack, g_data, g_inst;
  logic [31:0] e_addr, e_wdata, e_rd, m_irdata, m_drdata;
  logic [3:0]  e_we;
  int unsigned m_iwait, m_dgrant;

  // starvation-phase bookkeeping
  int          n_acks, first_i;
  byte         got [10];
  string       exp_order;

  task automatic rnd_inst();
    inst_addr = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 15));
  endtask

  task automatic rnd_data();
    data_wr    = 1'($urandom_range(0, 1));
    data_wstrb = 4'($urandom_range(0, 15));
    data_addr  = 32'h0000_2000 + 32'(4 * $urandom_range(0, 15));
    data_wdata = $urandom;
  endtask

  initial begin
    //          ireq  dreq  wr    strb  addr          wdata         pre   pre_val       we    iack  dack  irdata        drdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h1C000000, 32'h0,        1'b1, 32'h02800C0C, 4'h0, 1'b1, 1'b0, 32'h02800C0C, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h00001000, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 32'h02800C0C, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h00001000, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h02800C0C, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h00001000, 32'h11223344, 1'b0, 32'h0,        4'h3, 1'b0, 1'b1, 32'h02800C0C, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h00001000, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h02800C0C, 32'hDEAD3344};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h1C000004, 32'h0,        1'b1, 32'h12345678, 4'h0, 1'b1, 1'b0, 32'h12345678, 32'hDEAD3344};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'hC, 32'h00001004, 32'hA5A5A5A5, 1'b1, 32'h0,        4'hC, 1'b0, 1'b1, 32'h12345678, 32'hDEAD3344};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h00001004, 32'h0,        1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678, 32'hA5A50000};

    do_reset();
    check_all_zero("reset");

    // Single transactions from the table: grant, access at +1, ack at +2, idle at +3
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.preload) preload(v.addr, v.pre_val);
      inst_req = v.inst_req; inst_addr = v.addr;
      data_req = v.data_req; data_wr = v.data_wr; data_wstrb = v.wstrb;
      data_addr = v.addr; data_wdata = v.wdata;
      check("vec_busy_c0", 32'(busy), 32'h0);
      step();
      check("vec_sram_en_c1", 32'(sram_en), 32'h1);
      check("vec_sram_we_c1", 32'(sram_we), 32'(v.exp_we));
      check("vec_sram_addr_c1", sram_addr, v.addr);
      if (v.exp_we != 4'h0) check("vec_sram_wdata_c1", sram_wdata, v.wdata);
      check("vec_acks_c1", 32'({inst_ack, data_ack}), 32'h0);
      check("vec_busy_c1", 32'(busy), 32'h1);
      inst_addr = ~v.addr; data_addr = ~v.addr; data_wdata = ~v.wdata;
      step();
      check("vec_sram_en_c2", 32'(sram_en), 32'h0);
      check("vec_sram_we_c2", 32'(sram_we), 32'h0);
      check("vec_inst_ack_c2", 32'(inst_ack), 32'(v.exp_iack));
      check("vec_data_ack_c2", 32'(data_ack), 32'(v.exp_dack));
      check("vec_inst_rdata_c2", inst_rdata, v.exp_irdata);
      check("vec_data_rdata_c2", data_rdata, v.exp_drdata);
      inst_req = 1'b0; data_req = 1'b0;
      step();
      check("vec_acks_c3", 32'({inst_ack, data_ack}), 32'h0);
      check("vec_busy_c3", 32'(busy), 32'h0);
      check("vec_inst_rdata_hold", inst_rdata, v.exp_irdata);
      check("vec_data_rdata_hold", data_rdata, v.exp_drdata);
    end

    // Simultaneous requests: data first, inst next with the address present at its grant
    preload(32'h1C000008, 32'h0BADF00D);
    preload(32'h1C00000C, 32'hCAFE0001);
    inst_req = 1'b1; inst_addr = 32'h1C000008;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000;
    step();
    check("sim_c1_addr", sram_addr, 32'h1000);
    inst_addr = 32'h1C00000C;
    step();
    check("sim_c2_dack", 32'(data_ack), 32'h1);
    check("sim_c2_iack", 32'(inst_ack), 32'h0);
    check("sim_c2_drdata", data_rdata, 32'hDEAD3344);
    data_req = 1'b0;
    step();
    check("sim_c3_busy", 32'(busy), 32'h0);
    step();
    check("sim_c4_en", 32'(sram_en), 32'h1);
    check("sim_c4_addr", sram_addr, 32'h1C00000C);
    check("sim_c4_we", 32'(sram_we), 32'h0);
    step();
    check("sim_c5_iack", 32'(inst_ack), 32'h1);
    check("sim_c5_dack", 32'(data_ack), 32'h0);
    check("sim_c5_irdata", inst_rdata, 32'hCAFE0001);
    inst_req = 1'b0;
    step();

    // Reset coinciding with the ACCESS cycle of a load suppresses its ack
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1004;
    step();
    check("rst_c1_en", 32'(sram_en), 32'h1);
    check("rst_c1_addr", sram_addr, 32'h1004);
    reset = 1'b1; data_req = 1'b0;
    step();
    check_all_zero("rst_mid");
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    step();
    check("rst_after_en", 32'(sram_en), 32'h1);
    check("rst_after_dack", 32'(data_ack), 32'h0);
    step();
    check("rst_after_iack", 32'(inst_ack), 32'h1);
    check("rst_after_irdata", inst_rdata, 32'h02800C0C);
    inst_req = 1'b0;
    step();

    // Starvation: both held, STARVE_LIMIT data grants then one fetch
    do_reset();
    exp_order = "DDDDIDDDDI";
    n_acks = 0; first_i = -1;
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000;
    for (int c = 1; c <= 60 && n_acks < 10; c++) begin
      step();
      check("starve_ack_overlap", 32'(inst_ack & data_ack), 32'h0);
      if (inst_ack && first_i < 0) begin
        first_i = c;
        check("starve_first_iack_cycle", 32'(c), 32'd14);
        check("perf_inst_wait", inst_wait_cnt, PERF ? 32'd14 : 32'd0);
        check("perf_data_grant", data_grant_cnt, PERF ? 32'd4 : 32'd0);
      end
      if (data_ack && n_acks < 10) begin got[n_acks] = 8'h44; n_acks++; end
      if (inst_ack && n_acks < 10) begin got[n_acks] = 8'h49; n_acks++; end
    end
    check("starve_ack_count", 32'(n_acks), 32'd10);
    for (int k = 0; k < n_acks; k++) check("starve_grant_order", 32'(got[k]), 32'(exp_order[k]));
    inst_req = 1'b0; data_req = 1'b0;
    repeat (3) step();

    // Randomized traffic against the transaction-level model
    do_reset();
    free_at = 0; acc_t = -1; ack_t = -1; starv = 0;
    win_data = 1'b0; win_wr = 1'b0; inst_flight = 1'b0; data_flight = 1'b0;
    e_addr = '0; e_wdata = '0; e_rd = '0; e_we = '0;
    m_irdata = '0; m_drdata = '0; m_iwait = 0; m_dgrant = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t > 0) step();
      e_en   = (t == acc_t);
      e_iack = (t == ack_t) && !win_data;
      e_dack = (t == ack_t) && win_data;
      if (e_iack) m_irdata = e_rd;
      if (e_dack && !win_wr) m_drdata = e_rd;
      check("rnd_sram_en", 32'(sram_en), 32'(e_en));
      check("rnd_sram_we", 32'(sram_we), e_en ? 32'(e_we) : 32'h0);
      if (e_en) check("rnd_sram_addr", sram_addr, e_addr);
      if (e_en && e_we != 4'h0) check("rnd_sram_wdata", sram_wdata, e_wdata);
      check("rnd_inst_ack", 32'(inst_ack), 32'(e_iack));
      check("rnd_data_ack", 32'(data_ack), 32'(e_dack));
      check("rnd_inst_rdata", inst_rdata, m_irdata);
      check("rnd_data_rdata", data_rdata, m_drdata);
      check("rnd_busy", 32'(busy), 32'(t < free_at));
      check("rnd_inst_wait", inst_wait_cnt, PERF ? 32'(m_iwait) : 32'h0);
      check("rnd_data_grant", data_grant_cnt, PERF ? 32'(m_dgrant) : 32'h0);

      // fetch requester
      if (e_iack) begin
        inst_flight = 1'b0;
        if (inst_req && $urandom_range(0, 1) == 1) rnd_inst();
        else inst_req = 1'b0;
      end else if (inst_flight) begin
        r = $urandom_range(0, 7);
        if (r == 0) inst_req = 1'b0;
        else if (r < 4) rnd_inst();
      end else if (inst_req) begin
        r = $urandom_range(0, 15);
        if (r == 0) inst_req = 1'b0;
        else if (r < 5) rnd_inst();
      end else if ($urandom_range(0, 2) == 0) begin
        inst_req = 1'b1; rnd_inst();
      end

      // load/store requester
      if (e_dack) begin
        data_flight = 1'b0;
        if (data_req && $urandom_range(0, 1) == 1) rnd_data();
        else data_req = 1'b0;
      end else if (data_flight) begin
        r = $urandom_range(0, 7);
        if (r == 0) data_req = 1'b0;
        else if (r < 4) rnd_data();
      end else if (data_req) begin
        r = $urandom_range(0, 15);
        if (r == 0) data_req = 1'b0;
        else if (r < 5) rnd_data();
      end else if ($urandom_range(0, 2) == 0) begin
        data_req = 1'b1; rnd_data();
      end

      // arbiter is free: pick a winner with the starvation rule
      if (t >= free_at) begin
        g_data = data_req && (starv < LIMIT || !inst_req);
        g_inst = !g_data && inst_req;
        if (g_data || g_inst) begin
          win_data = g_data;
          acc_t = t + 1; ack_t = t + 2; free_at = t + 3;
          if (g_data) begin
            e_addr = data_addr; e_wdata = data_wdata; win_wr = data_wr;
            e_we = data_wr ? data_wstrb : 4'h0;
            if (data_wr) ref_mem[data_addr] = merge(ref_read(data_addr), data_wdata, data_wstrb);
            else e_rd = ref_read(data_addr);
            data_flight = 1'b1;
            m_dgrant++;
            if (inst_req && starv < LIMIT) starv++;
          end else begin
            e_addr = inst_addr; win_wr = 1'b0; e_we = 4'h0;
            e_rd = ref_read(inst_addr);
            inst_flight = 1'b1;
            starv = 0;
          end
        end
        if (!inst_req) starv = 0;
      end
      if (inst_req && !e_iack) m_iwait++;
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
